// File: rtl/calc_pkg.sv
// Shared constants for the calculator button front end: button codes and debounce default.
// Also holds the fixed-priority pick used to drain pending button events.
package calc_pkg;
  localparam logic [1:0] BTN_EQ  = 2'd0;
  localparam logic [1:0] BTN_MUL = 2'd1;
  localparam logic [1:0] BTN_SUB = 2'd2;
  localparam logic [1:0] BTN_ADD = 2'd3;
  localparam int         DEBOUNCE_CYCLES_DEF = 20000;
  localparam int         NUM_BTN = 4;

  // Lowest set bit wins; an all-zero vector yields BTN_ADD and must be gated by the caller.
  function automatic logic [1:0] lowest_btn(input logic [NUM_BTN-1:0] v);
    if (v[0])      return BTN_EQ;
    else if (v[1]) return BTN_MUL;
    else if (v[2]) return BTN_SUB;
    else           return BTN_ADD;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchronizer, 16-bit stability counter and debounced level register.
// Level toggles one edge after DEBOUNCE_CYCLES consecutive mismatching synchronized samples.
module btn_debounce import calc_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_level
);
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [1:0]  r_sync;
  logic [15:0] r_cnt;
  logic        r_level;
  logic        w_mismatch;
  logic        w_expire;

  assign w_mismatch = r_sync[1] ^ r_level;
  assign w_expire   = w_mismatch && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (!w_mismatch || w_expire) r_cnt <= '0;
      else                         r_cnt <= r_cnt + 16'd1;
      if (w_expire) r_level <= ~r_level;
    end
  end

  assign o_level = r_level;
endmodule

// File: rtl/btn_event_ctrl.sv
// Button event controller: four debouncers, press-edge pending bits, lowest-index-first event FIFO.
// Event visible DEBOUNCE_CYCLES+4 edges after a stable press; full FIFO without pop drops it and sets overflow.
module btn_event_ctrl import calc_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_BTN-1:0]           btn_raw,
  input  logic                         evt_pop,
  input  logic                         ovf_clr,
  output logic                         evt_valid,
  output logic [1:0]                   evt_code,
  output logic [$clog2(FIFO_DEPTH):0]  evt_count,
  output logic                         overflow,
  output logic [NUM_BTN-1:0]           btn_level
);
  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] r_level_q;
  logic [NUM_BTN-1:0] r_pending;
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_pend_clr;
  logic [1:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_ovf;
  logic               w_push_req;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [1:0]         w_push_code;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .i_raw   (btn_raw[g]),
      .o_level (w_level[g])
    );
  end

  // The head pending bit is retired every cycle, whether it lands in the FIFO or is dropped.
  assign w_rise      = w_level & ~r_level_q;
  assign w_push_req  = |r_pending;
  assign w_push_code = lowest_btn(r_pending);
  assign w_pend_clr  = w_push_req ? (NUM_BTN'(1) << w_push_code) : '0;
  assign w_full      = (r_count == FULL_CNT);
  assign w_pop       = evt_pop && (r_count != '0);
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_drop      = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level_q <= '0;
      r_pending <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_level_q <= w_level;
      r_pending <= (r_pending & ~w_pend_clr) | w_rise;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_code;
  end

  assign evt_valid = (r_count != '0);
  assign evt_code  = evt_valid ? r_mem[r_rd_ptr] : 2'd0;
  assign evt_count = r_count;
  assign overflow  = r_ovf;
  assign btn_level = w_level;
endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl: directed scenarios then random button/pop traffic, checked by a
// negedge monitor against a raw-sample debounce model and an expected-event queue.
module tb_btn_event_ctrl;
  localparam int D     = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] btn_raw;
  logic       evt_pop;
  logic       ovf_clr;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic [2:0] evt_count;
  logic       overflow;
  logic [3:0] btn_level;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  // Reference model: levels tracked in raw-sample time, delayed to DUT time via m_hist.
  int         exp_q[$];
  logic [3:0] m_pend;
  logic       m_ovf;
  logic [3:0] m_lvl;
  int         m_run[4];
  logic [3:0] m_hist[5];

  btn_event_ctrl #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_raw   (btn_raw),
    .evt_pop   (evt_pop),
    .ovf_clr   (ovf_clr),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_count (evt_count),
    .overflow  (overflow),
    .btn_level (btn_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pend = '0;
    m_ovf  = 1'b0;
    m_lvl  = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    for (int k = 0; k < 5; k++) m_hist[k] = '0;
  endtask

  task automatic model_step(input logic p, input logic c, input logic [3:0] raw);
    bit full, pop_ok, drop;
    int idx;
    full   = (exp_q.size() == DEPTH);
    pop_ok = p && (exp_q.size() != 0);
    drop   = 1'b0;
    idx    = -1;
    for (int i = 3; i >= 0; i--) if (m_pend[i]) idx = i;
    if (pop_ok) void'(exp_q.pop_front());
    if (idx >= 0) begin
      if (full && !pop_ok) drop = 1'b1;
      else exp_q.push_back(idx);
      m_pend[idx] = 1'b0;
    end
    if (drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    for (int k = 4; k > 0; k--) m_hist[k] = m_hist[k-1];
    for (int i = 0; i < 4; i++) begin
      if (raw[i] == m_lvl[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_lvl[i] = ~m_lvl[i];
          m_run[i] = 0;
        end
      end
    end
    m_hist[0] = m_lvl;
    m_pend = m_pend | (m_hist[3] & ~m_hist[4]);
  endtask

  task automatic tick();
    logic p, c;
    logic [3:0] r;
    p = evt_pop;
    c = ovf_clr;
    r = btn_raw;
    @(posedge clk);
    if (reset_n) model_step(p, c, r);
    else model_reset();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    while (n < lim) begin
      tick();
      n++;
      if (evt_valid) break;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, evt_valid, 0);
    check({tag, "_code"}, evt_code, 0);
    check({tag, "_count"}, evt_count, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_level"}, btn_level, 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("mon_count", evt_count, exp_q.size());
        check("mon_overflow", overflow, m_ovf);
        check("mon_level", btn_level, m_hist[2]);
        if (exp_q.size() != 0) begin
          check("mon_valid", evt_valid, 1);
          check("mon_code", evt_code, exp_q[0]);
        end else begin
          check("mon_valid", evt_valid, 0);
          check("mon_code_empty", evt_code, 0);
        end
      end
    end
  end

  initial begin
    int n;
    int len;
    int codes[4];
    int hold[4];
    logic seen_l, seen_v;

    reset_n = 1'b0;
    btn_raw = '0;
    evt_pop = 1'b0;
    ovf_clr = 1'b0;
    model_reset();
    idle(3);
    check_all_zero("reset");
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Single press latency
    btn_raw[0] = 1'b1;
    wait_valid(100, n);
    check("latency_btn0", n, D + 4);
    check("code_btn0", evt_code, 0);
    check("count_btn0", evt_count, 1);
    btn_raw[0] = 1'b0;
    evt_pop = 1'b1;
    tick();
    evt_pop = 1'b0;
    idle(D + 6);

    // Pulses shorter than D must be filtered
    for (int t = 0; t < 2; t++) begin
      len = (t == 0) ? 5 : D - 1;
      seen_l = 1'b0;
      seen_v = 1'b0;
      btn_raw[2] = 1'b1;
      repeat (len) begin tick(); seen_l |= btn_level[2]; seen_v |= evt_valid; end
      btn_raw[2] = 1'b0;
      repeat (D + 8) begin tick(); seen_l |= btn_level[2]; seen_v |= evt_valid; end
      check("short_pulse_level", seen_l, 0);
      check("short_pulse_event", seen_v, 0);
    end

    // Pulse of exactly D samples is accepted
    btn_raw[1] = 1'b1;
    idle(D);
    btn_raw[1] = 1'b0;
    wait_valid(40, n);
    check("exact_D_latency", D + n, D + 4);
    check("exact_D_code", evt_code, 1);
    evt_pop = 1'b1;
    tick();
    evt_pop = 1'b0;
    idle(D + 6);

    // All four together: drained lowest index first, one per cycle
    btn_raw = 4'hF;
    wait_valid(100, n);
    check("burst_latency", n, D + 4);
    idle(3);
    check("burst_count", evt_count, 4);
    check("burst_head", evt_code, 0);
    btn_raw = 4'h0;
    idle(D + 6);

    // Fifth press into full FIFO, ovf_clr in the same cycle: set wins
    btn_raw[1] = 1'b1;
    idle(D + 3);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_set_wins", overflow, 1);
    check("ovf_count_full", evt_count, 4);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);
    btn_raw[1] = 1'b0;
    idle(D + 6);

    // Fifth press with a pop in the push cycle
    btn_raw[2] = 1'b1;
    idle(D + 3);
    evt_pop = 1'b1;
    tick();
    evt_pop = 1'b0;
    check("pushpop_no_ovf", overflow, 0);
    check("pushpop_count", evt_count, 4);
    for (int i = 0; i < 4; i++) begin
      codes[i] = evt_code;
      evt_pop = 1'b1;
      tick();
    end
    evt_pop = 1'b0;
    check("drain_first", codes[0], 1);
    check("drain_tail", codes[3], 2);
    btn_raw = 4'h0;
    idle(D + 6);

    // Pop on empty is ignored
    evt_pop = 1'b1;
    idle(3);
    evt_pop = 1'b0;
    check("empty_pop_count", evt_count, 0);
    check("empty_pop_valid", evt_valid, 0);

    // Reset with 3 queued events and btn1 half-debounced
    btn_raw = 4'b1101;
    wait_valid(100, n);
    idle(2);
    check("pre_reset_count", evt_count, 3);
    btn_raw[1] = 1'b1;
    idle(D / 2);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_reset");
    btn_raw = 4'b0010;
    idle(2);
    reset_n = 1'b1;
    wait_valid(100, n);
    check("post_reset_latency", n, D + 4);
    check("post_reset_code", evt_code, 1);
    idle(D + 8);
    check("post_reset_single", evt_count, 1);
    evt_pop = 1'b1;
    tick();
    evt_pop = 1'b0;
    btn_raw = 4'h0;
    idle(D + 6);

    // Random traffic: bouncy buttons, random pops and clears, one mid-run reset
    for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 2 * D + 4);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin
          btn_raw[i] = ~btn_raw[i];
          hold[i] = $urandom_range(1, 2 * D + 4);
        end
      end
      evt_pop = ($urandom_range(0, 99) < ((cyc < 2000) ? 15 : 60));
      ovf_clr = ($urandom_range(0, 99) < 4);
      if (cyc == 3000) begin
        reset_n = 1'b0;
        model_reset();
        idle(2);
        reset_n = 1'b1;
      end
      tick();
    end
    evt_pop = 1'b0;
    ovf_clr = 1'b0;
    idle(2);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
